uart_rx_deser: RTL

//   UART receive deserializer: the consumer of a UART transmitter's tx line.

---
 rtl/uart_rx_deser.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART 8N1 receive deserializer.
//   Synchronizes the asynchronous rx line, finds the start bit, samples each
//   data bit and the stop bit at mid-bit and presents the received byte on
//   data_out with a data_ready level that holds until the host acknowledges it.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low; clears all state
//   rx            serial line, idle high, asynchronous to clk
//   data_ack      1-cycle pulse; host consumed data_out (clears all flags)
//   data_out      last good byte received
//   data_ready    new byte waiting in data_out
//   framing_error sticky; a stop bit was sampled low
//   overrun       sticky; a byte landed while data_ready was still set
//   busy          high whenever the receiver is not idle
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state, state_nxt;
    logic                   rx_m, rx_s;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;

    logic                   cnt_clr;
    logic                   idx_clr;
    logic                   shift_en;
    logic                   load;
    logic                   ferr_set;

    // Two-flop synchronizer; both flops reset to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IDLE and BREAK hold cnt at zero, so every state is entered with cnt==0.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        load      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clr   = 1'b1;
                    idx_clr   = 1'b1;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        load      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_clr = 1'b1;
                if (rx_s) state_nxt = S_IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + BW'(1);
            end
            // LSB-first line: shift in at the MSB so the first bit ends in bit 0.
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // A load coinciding with data_ack keeps data_ready set and does not count
    // as an overrun; the ack still clears any older overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out      <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (load) begin
                data_out <= shift_reg;
            end

            if (load) begin
                data_ready <= 1'b1;
            end else if (data_ack) begin
                data_ready <= 1'b0;
            end

            if (load && data_ready && !data_ack) begin
                overrun <= 1'b1;
            end else if (data_ack) begin
                overrun <= 1'b0;
            end

            if (ferr_set) begin
                framing_error <= 1'b1;
            end else if (data_ack) begin
                framing_error <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
